// File: rtl/imem_loader.sv
// Boot loader: turns a count-prefixed little-endian byte stream into 19-bit words,
// writes them to instruction memory, pads the tail and then releases the CPU.
`timescale 1ns/1ps
module imem_loader #(
    parameter int                WORD_W         = 19,
    parameter int                DEPTH          = 32,
    parameter int                ADDR_W         = 5,
    parameter logic [WORD_W-1:0] PAD_WORD       = '0,
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [5:0]        words_loaded
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_B0    = 3'd1;
    localparam logic [2:0] S_B1    = 3'd2;
    localparam logic [2:0] S_B2    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_FILL  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]        state_q, state_d;
    logic [5:0]        count_q, count_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [5:0]        words_q, words_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              xfer;

    assign xfer = byte_valid && ready_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        words_d = words_q;
        to_d    = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        // Idle-cycle watchdog while waiting on word bytes; any transfer or
        // state change leaves to_d at its zero default.
        if ((state_q == S_B0 || state_q == S_B1 || state_q == S_B2) && !xfer) begin
            if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_ERROR;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (byte_data == 8'd0 || int'(byte_data) > DEPTH) begin
                        state_d = S_ERROR;
                    end else begin
                        count_d = byte_data[5:0];
                        idx_d   = '0;
                        state_d = S_B0;
                    end
                end
            end
            S_B0: begin
                if (xfer) begin
                    b0_d    = byte_data;
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (xfer) begin
                    b1_d    = byte_data;
                    state_d = S_B2;
                end
            end
            S_B2: begin
                if (xfer) begin
                    if (byte_data[7:3] != 5'd0) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        addr_d  = idx_q;
                        wdata_d = WORD_W'({byte_data[2:0], b1_q, b0_q});
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + ADDR_W'(1);
                words_d = words_q + 6'd1;
                if (6'(idx_q) + 6'd1 == count_q) begin
                    if (int'(count_q) == DEPTH) begin
                        state_d = S_DONE;
                    end else begin
                        // Padding starts at the first address past the program.
                        state_d = S_FILL;
                        we_d    = 1'b1;
                        addr_d  = idx_q + ADDR_W'(1);
                        wdata_d = PAD_WORD;
                    end
                end else begin
                    state_d = S_B0;
                end
            end
            S_FILL: begin
                if (addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    wdata_d = PAD_WORD;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_IDLE;
                    words_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        ready_d     = (state_d == S_IDLE) || (state_d == S_B0) ||
                      (state_d == S_B1)   || (state_d == S_B2);
        cpu_reset_d = (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            to_q        <= '0;
            words_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            to_q        <= to_d;
            words_q     <= words_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign byte_ready   = ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = done_q;
    assign load_error   = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a negedge memory model records every write and
// each scenario task checks the loaded image and status outputs inline.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 1024;
    localparam logic [18:0] SENTINEL = 19'h5A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [18:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [5:0]  words_loaded;

    int tests = 0;
    int fails = 0;
    bit stim_ok;

    logic [18:0] mem_model [DEPTH];
    int          wr_count = 0;
    bit          clr_tog = 1'b0;
    bit          clr_seen = 1'b0;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr_tog != clr_seen) begin
            for (int i = 0; i < DEPTH; i++) mem_model[i] = SENTINEL;
            clr_seen = clr_tog;
        end
        if (imem_we === 1'b1) begin
            mem_model[imem_addr] = imem_wdata;
            wr_count++;
        end
    end

    function automatic logic [18:0] pat(input int i);
        return 19'((i * 32'h0ABCD) + 32'h00123);
    endfunction

    task automatic clear_model();
        clr_tog = ~clr_tog;
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (byte_ready !== 1'b1) stim_ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'hEE;
    endtask

    task automatic send_word(input logic [18:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte({5'd0, w[18:16]});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (load_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        tests++; if (byte_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%0b exp=1", byte_ready); end
        tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_we got=%0b exp=0", imem_we); end
        tests++; if (imem_addr !== 5'd0) begin fails++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
        tests++; if (imem_wdata !== 19'd0) begin fails++; $display("FAIL reset_wdata got=%h exp=0", imem_wdata); end
        tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL reset_cpu_reset got=%0b exp=1", cpu_reset); end
        tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%0b exp=0", load_done); end
        tests++; if (load_error !== 1'b0) begin fails++; $display("FAIL reset_error got=%0b exp=0", load_error); end
        tests++; if (words_loaded !== 6'd0) begin fails++; $display("FAIL reset_words got=%0d exp=0", words_loaded); end
        $display("[TB] reset checked");
    endtask

    task automatic test_two_words();
        int base;
        bit ok;
        int bad;
        logic [7:0] stream [7];
        stream = '{8'h02, 8'hFF, 8'hFF, 8'h07, 8'h45, 8'h23, 8'h01};
        clear_model();
        base = wr_count;
        stim_ok = 1'b1;
        foreach (stream[i]) send_byte(stream[i]);
        wait_done(100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL two_done_timeout load_done=%0b exp=1", load_done); end
        tests++; if (mem_model[0] !== 19'h7FFFF) begin fails++; $display("FAIL two_addr0 got=%h exp=7ffff", mem_model[0]); end
        tests++; if (mem_model[1] !== 19'h12345) begin fails++; $display("FAIL two_addr1 got=%h exp=12345", mem_model[1]); end
        bad = 0;
        for (int a = 2; a < DEPTH; a++) if (mem_model[a] !== 19'd0) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL two_fill %0d pad entries wrong, exp 0", bad); end
        tests++; if (wr_count - base != 32) begin fails++; $display("FAIL two_writes got=%0d exp=32", wr_count - base); end
        tests++; if (cpu_reset !== 1'b0) begin fails++; $display("FAIL two_cpu_reset got=%0b exp=0", cpu_reset); end
        tests++; if (words_loaded !== 6'd2) begin fails++; $display("FAIL two_words got=%0d exp=2", words_loaded); end
        tests++; if (stim_ok !== 1'b1) begin fails++; $display("FAIL two_handshake ready not seen"); end
        $display("[TB] two-word load: writes=%0d words=%0d", wr_count - base, words_loaded);
    endtask

    task automatic test_full();
        int base;
        int bad;
        pulse_start();
        tests++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL full_start cpu_reset=%0b done=%0b exp 1/0", cpu_reset, load_done); end
        tests++; if (words_loaded !== 6'd0 || byte_ready !== 1'b1) begin fails++; $display("FAIL full_start_idle words=%0d ready=%0b exp 0/1", words_loaded, byte_ready); end
        clear_model();
        base = wr_count;
        stim_ok = 1'b1;
        send_byte(8'd32);
        for (int i = 0; i < DEPTH; i++) send_word(pat(i));
        tests++; if (imem_we !== 1'b1 || imem_addr !== 5'd31) begin fails++; $display("FAIL full_last_write we=%0b addr=%0d exp 1/31", imem_we, imem_addr); end
        @(posedge clk);
        #1;
        tests++; if (load_done !== 1'b1 || imem_we !== 1'b0) begin fails++; $display("FAIL full_done_next done=%0b we=%0b exp 1/0", load_done, imem_we); end
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem_model[a] !== pat(a)) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL full_image %0d entries wrong, exp 0", bad); end
        tests++; if (wr_count - base != 32) begin fails++; $display("FAIL full_writes got=%0d exp=32", wr_count - base); end
        tests++; if (words_loaded !== 6'd32) begin fails++; $display("FAIL full_words got=%0d exp=32", words_loaded); end
        tests++; if (stim_ok !== 1'b1) begin fails++; $display("FAIL full_handshake ready not seen"); end
        $display("[TB] full load: writes=%0d words=%0d", wr_count - base, words_loaded);
    endtask

    task automatic test_bad_count();
        int base;
        logic [7:0] counts [2];
        counts = '{8'd0, 8'd33};
        pulse_start();
        foreach (counts[k]) begin
            base = wr_count;
            send_byte(counts[k]);
            repeat (3) @(posedge clk);
            #1;
            tests++; if (load_error !== 1'b1 || byte_ready !== 1'b0) begin fails++; $display("FAIL badcnt_%0d error=%0b ready=%0b exp 1/0", counts[k], load_error, byte_ready); end
            tests++; if (wr_count != base || cpu_reset !== 1'b1) begin fails++; $display("FAIL badcnt_%0d_writes writes=%0d cpu_reset=%0b exp 0/1", counts[k], wr_count - base, cpu_reset); end
            pulse_start();
            tests++; if (byte_ready !== 1'b1 || load_error !== 1'b0) begin fails++; $display("FAIL badcnt_%0d_restart ready=%0b error=%0b exp 1/0", counts[k], byte_ready, load_error); end
            $display("[TB] bad count %0d rejected", counts[k]);
        end
    endtask

    task automatic test_bad_b2();
        int base;
        base = wr_count;
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        tests++; if (load_error !== 1'b0) begin fails++; $display("FAIL badb2_early error=%0b exp=0", load_error); end
        send_byte(8'h08);
        tests++; if (load_error !== 1'b1) begin fails++; $display("FAIL badb2_error got=%0b exp=1", load_error); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (wr_count != base || cpu_reset !== 1'b1) begin fails++; $display("FAIL badb2_writes writes=%0d cpu_reset=%0b exp 0/1", wr_count - base, cpu_reset); end
        tests++; if (words_loaded !== 6'd0) begin fails++; $display("FAIL badb2_words got=%0d exp=0", words_loaded); end
        pulse_start();
        $display("[TB] bad third byte rejected");
    endtask

    task automatic test_timeout();
        bit ok;
        clear_model();
        send_byte(8'h01);
        send_byte(8'hAA);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        send_byte(8'hBB);
        send_byte(8'h03);
        wait_done(100, ok);
        tests++; if (!ok || load_error !== 1'b0) begin fails++; $display("FAIL to_short done=%0b error=%0b exp 1/0", load_done, load_error); end
        tests++; if (mem_model[0] !== 19'h3BBAA) begin fails++; $display("FAIL to_short_word got=%h exp=3bbaa", mem_model[0]); end
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hAA);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        tests++; if (load_error !== 1'b0) begin fails++; $display("FAIL to_before error=%0b exp=0", load_error); end
        @(posedge clk);
        #1;
        tests++; if (load_error !== 1'b1 || byte_ready !== 1'b0) begin fails++; $display("FAIL to_expire error=%0b ready=%0b exp 1/0", load_error, byte_ready); end
        pulse_start();
        $display("[TB] timeout boundary checked");
    endtask

    task automatic test_reset_midload();
        bit ok;
        int bad;
        int base;
        send_byte(8'd5);
        for (int i = 0; i < 3; i++) send_word(pat(i + 7));
        send_byte(8'h5C);
        reset = 1'b1;
        #1;
        tests++; if (byte_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== 5'd0 || imem_wdata !== 19'd0) begin fails++; $display("FAIL mid_reset_mem ready=%0b we=%0b addr=%0d wdata=%h exp 1/0/0/0", byte_ready, imem_we, imem_addr, imem_wdata); end
        tests++; if (cpu_reset !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 || words_loaded !== 6'd0) begin fails++; $display("FAIL mid_reset_status cpu=%0b done=%0b err=%0b words=%0d exp 1/0/0/0", cpu_reset, load_done, load_error, words_loaded); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        base = wr_count;
        stim_ok = 1'b1;
        send_byte(8'd5);
        for (int i = 0; i < 5; i++) send_word(pat(i + 40));
        wait_done(100, ok);
        tests++; if (!ok || cpu_reset !== 1'b0) begin fails++; $display("FAIL mid_reload_done done=%0b cpu_reset=%0b exp 1/0", load_done, cpu_reset); end
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (a < 5 && mem_model[a] !== pat(a + 40)) bad++;
            if (a >= 5 && mem_model[a] !== 19'd0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL mid_reload_image %0d entries wrong, exp 0", bad); end
        tests++; if (words_loaded !== 6'd5 || wr_count - base != 32) begin fails++; $display("FAIL mid_reload_counts words=%0d writes=%0d exp 5/32", words_loaded, wr_count - base); end
        tests++; if (stim_ok !== 1'b1) begin fails++; $display("FAIL mid_handshake ready not seen"); end
        pulse_start();
        tests++; if (cpu_reset !== 1'b1 || load_done !== 1'b0 || words_loaded !== 6'd0) begin fails++; $display("FAIL mid_restart cpu=%0b done=%0b words=%0d exp 1/0/0", cpu_reset, load_done, words_loaded); end
        $display("[TB] mid-load reset and reload checked");
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_two_words();
        test_full();
        test_bad_count();
        test_bad_b2();
        test_timeout();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the 19-bit CPU core.
- Receives a byte stream over a valid/ready handshake and assembles 19-bit instruction words.
- Writes the words into the 32-entry instruction memory, padding unused entries.
- Holds the CPU in reset until a complete, well-formed program has been written.

Parameters:
- WORD_W, 19, instruction width in bits.
- DEPTH, 32, instruction memory entries.
- ADDR_W, 5, instruction memory address width.
- PAD_WORD, 19'd0, value written to entries beyond the loaded program.
- TIMEOUT_CYCLES, 1024, maximum idle cycles between bytes of an active load.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a new load from DONE or ERROR.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  instruction memory write address.
- imem_wdata  output  WORD_W  instruction memory write data.
- cpu_reset  output  1  reset to the CPU core; high except in DONE.
- load_done  output  1  program loaded; CPU running.
- load_error  output  1  load aborted.
- words_loaded  output  6  count of program words written, 0..32.

Behaviour:
- Reset (async): state=IDLE, byte_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, words_loaded=0, timeout counter=0. Memory contents are not touched.
- Handshake: a byte transfers on a rising edge with byte_valid && byte_ready. byte_ready=1 only in IDLE, B0, B1 and B2; 0 in all other states. byte_data is ignored when no transfer occurs.
- Stream format: one count byte N, then N words of 3 bytes each, little-endian.
  - b0 = word[7:0]
  - b1 = word[15:8]
  - b2[2:0] = word[18:16]
  - b2[7:3] must be 0.
- IDLE: on transfer, N=byte_data.
  - N==0 or N>DEPTH -> ERROR.
  - Otherwise latch N, idx=0, go to B0.
- B0 -> B1 -> B2: each state advances on a transfer. In B2, if b2[7:3]!=0 -> ERROR; otherwise go to WRITE.
- WRITE: lasts exactly 1 cycle.
  - imem_we=1, imem_addr=idx, imem_wdata=assembled word.
  - words_loaded increments; idx increments.
  - If idx+1==N -> FILL (or -> DONE when N==DEPTH); otherwise -> B0.
- FILL: 1 write per cycle of PAD_WORD to addresses N..DEPTH-1, imem_we=1 each cycle. After address DEPTH-1 -> DONE. Latency is DEPTH-N cycles. words_loaded is unchanged in FILL.
- DONE: cpu_reset=0 from the first cycle in DONE; load_done=1; imem_we=0.
  - start -> IDLE, reasserting cpu_reset in the same edge, clearing load_done and words_loaded.
  - byte_valid is ignored.
- ERROR: load_error=1, cpu_reset=1, imem_we=0. Sticky.
  - start -> IDLE, clearing load_error and words_loaded.
  - Partially written memory is left as is.
- Timeout: in B0, B1 and B2 the counter increments each cycle without a transfer. It clears on every transfer and on every state change. Reaching TIMEOUT_CYCLES -> ERROR. There is no timeout in IDLE.
- start outside DONE/ERROR: ignored.
- Simultaneous start and byte_valid in DONE/ERROR: start wins; the byte is not accepted because byte_ready=0.
- imem_addr wraps never: index range is guaranteed by the N<=DEPTH check.
- Outputs are registered. imem_we, imem_addr and imem_wdata are valid in the same cycle the state is WRITE or FILL.
- Reset mid-load: immediate return to the reset values; the load restarts from the count byte.

Test Plan:
- Count 2, words 19'h7FFFF and 19'h12345 (bytes 02 FF FF 07 45 23 01): addr0=7FFFF, addr1=12345, addrs 2..31=0 via 30 FILL writes. Then load_done=1, cpu_reset=0, words_loaded=2.
- Count 32, 96 bytes: 32 writes, zero FILL cycles, DONE directly after the last WRITE.
- Count 0, and separately count 33: load_error=1, no imem_we pulses. start -> IDLE with byte_ready=1.
- Third byte 0x08 on word 0: ERROR after B2, zero writes, cpu_reset stays 1.
- Stall byte_valid low for TIMEOUT_CYCLES-1 cycles in B1, then send a byte: load continues. Stall for TIMEOUT_CYCLES cycles: ERROR.
- Assert reset during word 3 of 5: all outputs return to reset values. A fresh 5-word load then completes correctly; start in DONE reasserts cpu_reset.
